inv_bank_bist: RTL

- Parametrised built-in self-test sequencer for a WIDTH-channel CMOS inverter bank.
- Drives a fixed pattern set onto the bank inputs (stim). For each pattern it waits a programmable settle time, then samples the bank outputs (resp) and checks resp == ~stim per bit.
- Accumulates a per-channel sticky fail mask and a failing-pattern count, and reports pass/fail with a one-cycle done strobe.
- Sits between the test controller (start) and the gate-level inverter array under test.

---
 rtl/inv_bank_bist.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/inv_bank_bist.sv
// BIST sequencer for a WIDTH-channel inverter bank: applies zeros, ones and walking-one patterns, checks resp == ~stim.
// Optional first-failing-pattern capture is enabled by defining BIST_FIRST_FAIL_EN.
module inv_bank_bist #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned SETTLE = 2,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] resp,
    output logic [WIDTH-1:0] stim,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] fail_mask,
`ifdef BIST_FIRST_FAIL_EN
    output logic [CNT_W-1:0] err_count,
    output logic             first_fail_vld,
    output logic [5:0]       first_fail_idx
`else
    output logic [CNT_W-1:0] err_count
`endif
);

    typedef enum logic [2:0] {IDLE, APPLY, WAIT, CHECK, FINISH} state_t;

    localparam logic [5:0] P_LAST = 6'(WIDTH + 1);
    localparam logic [7:0] W_LAST = (SETTLE > 0) ? 8'(SETTLE - 1) : 8'd0;

    state_t           state, state_n;
    logic [5:0]       p, p_n;
    logic [7:0]       wcnt, wcnt_n;
    logic [WIDTH-1:0] stim_n, mask_n, mism;
    logic [CNT_W-1:0] err_n;
    logic             pass_n;
`ifdef BIST_FIRST_FAIL_EN
    logic             ffv_n;
    logic [5:0]       ffi_n;
`endif

    function automatic logic [WIDTH-1:0] pattern(input logic [5:0] idx);
        logic [WIDTH-1:0] v;
        v = (idx == 6'd1) ? '1 : '0;
        for (int unsigned k = 0; k < WIDTH; k++) begin
            if (idx == 6'(k + 2)) v[k] = 1'b1;
        end
        return v;
    endfunction

    always_comb begin
        state_n = state;
        p_n     = p;
        wcnt_n  = wcnt;
        stim_n  = stim;
        mask_n  = fail_mask;
        err_n   = err_count;
        pass_n  = pass;
        mism    = resp ^ ~stim;
`ifdef BIST_FIRST_FAIL_EN
        ffv_n   = first_fail_vld;
        ffi_n   = first_fail_idx;
`endif
        case (state)
            IDLE: begin
                stim_n = '0;
                if (start) begin
                    mask_n  = '0;
                    err_n   = '0;
                    pass_n  = 1'b0;
                    p_n     = 6'd0;
                    wcnt_n  = 8'd0;
                    stim_n  = pattern(6'd0);
                    state_n = APPLY;
`ifdef BIST_FIRST_FAIL_EN
                    ffv_n   = 1'b0;
                    ffi_n   = 6'd0;
`endif
                end
            end
            APPLY: begin
                wcnt_n  = 8'd0;
                state_n = (SETTLE == 0) ? CHECK : WAIT;
            end
            WAIT: begin
                if (wcnt == W_LAST) begin
                    wcnt_n  = 8'd0;
                    state_n = CHECK;
                end else begin
                    wcnt_n = wcnt + 8'd1;
                end
            end
            CHECK: begin
                mask_n = fail_mask | mism;
                if (mism != '0 && err_count != '1) err_n = err_count + 1'b1;
`ifdef BIST_FIRST_FAIL_EN
                if (mism != '0 && !first_fail_vld) begin
                    ffv_n = 1'b1;
                    ffi_n = p;
                end
`endif
                // pass is decided from the mask including this final check
                if (p == P_LAST) begin
                    stim_n  = '0;
                    pass_n  = (mask_n == '0);
                    state_n = FINISH;
                end else begin
                    p_n     = p + 6'd1;
                    stim_n  = pattern(p + 6'd1);
                    state_n = APPLY;
                end
            end
            FINISH: begin
                stim_n  = '0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            p         <= 6'd0;
            wcnt      <= 8'd0;
            stim      <= '0;
            fail_mask <= '0;
            err_count <= '0;
            pass      <= 1'b0;
`ifdef BIST_FIRST_FAIL_EN
            first_fail_vld <= 1'b0;
            first_fail_idx <= 6'd0;
`endif
        end else begin
            state     <= state_n;
            p         <= p_n;
            wcnt      <= wcnt_n;
            stim      <= stim_n;
            fail_mask <= mask_n;
            err_count <= err_n;
            pass      <= pass_n;
`ifdef BIST_FIRST_FAIL_EN
            first_fail_vld <= ffv_n;
            first_fail_idx <= ffi_n;
`endif
        end
    end

    always_comb begin
        busy = (state == APPLY) || (state == WAIT) || (state == CHECK);
        done = (state == FINISH);
    end

endmodule
